slave_in_port: RTL and testbench

Slave-side receiver for the serial system bus driven by the master output port. It deserialises the address, burst count and write data from the bus lines, LSB first. For writes it issues one parallel memory write strobe per beat. For reads it issues one read request per beat to the slave's read-return path. It sits between the bus mux and the slave's local memory and returns slave_ready and rx_done to the master.

---
 rtl/bus_pkg.sv | 18 +
 rtl/serial_rx_shift.sv | 36 +++
 rtl/slave_in_port.sv | 143 ++++++++++++++
 tb/tb_slave_in_port.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus sizing defaults and the slave receive state encoding.
package bus_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 12;
  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_BURST_WIDTH = 12;

  typedef enum logic [2:0] {
    IDLE,
    RX_HDR,
    RX_DATA,
    MEM_WR,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/serial_rx_shift.sv
// LSB-first serial-in/parallel-out register with bit counter; stops shifting once full.
module serial_rx_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;
  logic          full;

  assign full = (count == CW'(WIDTH));
  // High while the next accepted bit completes the field.
  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      data  <= '0;
      count <= '0;
    end else if (clr) begin
      data  <= '0;
      count <= '0;
    end else if (en && !full) begin
      data  <= {din, data[WIDTH-1:1]};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// Slave-side serial bus receiver: deserialises header and write data, issues
// per-beat memory write strobes or read requests, and reports completion.
module slave_in_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned BURST_WIDTH = DEF_BURST_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  master_valid,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic                  rx_address,
  input  logic                  rx_burst_num,
  input  logic                  rx_data,
  input  logic                  slave_busy,
  input  logic                  read_ack,
  output logic                  slave_ready,
  output logic                  rx_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  read_req,
  output logic                  proto_err
);

  state_t state_q, state_d;

  logic                   is_write_q;
  logic [BURST_WIDTH-1:0] beats_q;
  logic [ADDR_WIDTH-1:0]  cur_addr_q;

  logic [ADDR_WIDTH-1:0]  addr_sr;
  logic [BURST_WIDTH-1:0] burst_sr;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic                   addr_last, burst_last, data_last;
  logic [ADDR_WIDTH-1:0]  addr_val;
  logic [BURST_WIDTH-1:0] burst_val;

  logic start, illegal, hdr_en, hdr_clr, hdr_end;
  logic data_en, data_clr, data_end, strobe, ack, beats_last;
  logic ready_d, we_d, req_d, done_d, err_d;

  assign start      = (state_q == IDLE) && master_valid && (write_en ^ read_en);
  assign illegal    = (state_q == IDLE) && master_valid && write_en && read_en;
  assign hdr_en     = start || ((state_q == RX_HDR) && master_valid);
  assign hdr_clr    = (state_q != IDLE) && (state_q != RX_HDR);
  assign hdr_end    = (state_q == RX_HDR) && master_valid && addr_last && burst_last;
  assign data_en    = (state_q == RX_DATA) && master_valid;
  assign data_end   = data_en && data_last;
  assign strobe     = (state_q == MEM_WR) && !slave_busy;
  assign data_clr   = strobe || ((state_q != RX_DATA) && (state_q != MEM_WR));
  assign ack        = (state_q == RD_WAIT) && read_ack;
  assign beats_last = (beats_q == BURST_WIDTH'(1));

  // Header fields are taken on the edge of their final bit, so fold that bit in here.
  assign addr_val  = {rx_address, addr_sr[ADDR_WIDTH-1:1]};
  assign burst_val = {rx_burst_num, burst_sr[BURST_WIDTH-1:1]};

  serial_rx_shift #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk(clk), .reset(reset), .en(hdr_en), .clr(hdr_clr),
    .din(rx_address), .data(addr_sr), .last(addr_last)
  );

  serial_rx_shift #(.WIDTH(BURST_WIDTH)) u_burst_sr (
    .clk(clk), .reset(reset), .en(hdr_en), .clr(hdr_clr),
    .din(rx_burst_num), .data(burst_sr), .last(burst_last)
  );

  serial_rx_shift #(.WIDTH(DATA_WIDTH)) u_data_sr (
    .clk(clk), .reset(reset), .en(data_en), .clr(data_clr),
    .din(rx_data), .data(data_sr), .last(data_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RX_HDR;
      RX_HDR:  if (hdr_end) state_d = is_write_q ? RX_DATA : RD_REQ;
      RX_DATA: if (data_end) state_d = MEM_WR;
      MEM_WR:  if (strobe) state_d = beats_last ? DONE : RX_DATA;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: if (ack) state_d = beats_last ? DONE : RD_REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d == IDLE) || (state_d == RX_HDR) || (state_d == RX_DATA);
    we_d    = strobe;
    req_d   = (state_q == RD_REQ);
    done_d  = (state_q == DONE);
    err_d   = illegal;
  end

  // mem_address presents the beat being issued; cur_addr_q runs one beat ahead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      is_write_q  <= 1'b0;
      beats_q     <= '0;
      cur_addr_q  <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      slave_ready <= 1'b0;
      mem_we      <= 1'b0;
      read_req    <= 1'b0;
      rx_done     <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      slave_ready <= ready_d;
      mem_we      <= we_d;
      read_req    <= req_d;
      rx_done     <= done_d;
      proto_err   <= err_d;
      if (start) is_write_q <= write_en;
      if (hdr_end) begin
        cur_addr_q  <= addr_val;
        mem_address <= addr_val;
        beats_q     <= (burst_val == '0) ? BURST_WIDTH'(1) : burst_val;
      end
      if (strobe) begin
        mem_address <= cur_addr_q;
        mem_wdata   <= data_sr;
        cur_addr_q  <= cur_addr_q + 1'b1;
        beats_q     <= beats_q - 1'b1;
      end
      if (state_q == RD_REQ) mem_address <= cur_addr_q;
      if (ack) begin
        cur_addr_q <= cur_addr_q + 1'b1;
        beats_q    <= beats_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// Directed self-checking bench for slave_in_port.
module tb_slave_in_port;

  logic        clk;
  logic        reset;
  logic        master_valid, write_en, read_en;
  logic        rx_address, rx_burst_num, rx_data;
  logic        slave_busy, read_ack;
  logic        slave_ready, rx_done, mem_we, read_req, proto_err;
  logic [11:0] mem_address;
  logic [7:0]  mem_wdata;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int req_cnt  = 0;
  int done_cnt = 0;

  slave_in_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .BURST_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .master_valid(master_valid),
    .write_en(write_en), .read_en(read_en),
    .rx_address(rx_address), .rx_burst_num(rx_burst_num), .rx_data(rx_data),
    .slave_busy(slave_busy), .read_ack(read_ack),
    .slave_ready(slave_ready), .rx_done(rx_done),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .read_req(read_req), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1)   we_cnt++;
    if (read_req === 1'b1) req_cnt++;
    if (rx_done === 1'b1)  done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [11:0] a, input logic [11:0] b, input logic wr,
                          input int gap_after, input int gap_len);
    for (int i = 0; i < 12; i++) begin
      master_valid = 1'b1;
      rx_address   = a[i];
      rx_burst_num = b[i];
      write_en     = (i == 0) && wr;
      read_en      = (i == 0) && !wr;
      tick();
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          master_valid = 1'b0;
          rx_address   = ~a[i];
          rx_burst_num = 1'b1;
          tick();
        end
      end
    end
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      master_valid = 1'b1;
      rx_data      = d[i];
      tick();
    end
    master_valid = 1'b0;
    rx_data      = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({slave_ready, rx_done, mem_we, read_req, proto_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {slave_ready, rx_done, mem_we, read_req, proto_err});
    end
    checks++;
    if ({mem_address, mem_wdata} !== 20'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 00000", {mem_address, mem_wdata});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (slave_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: got %b expected 1", slave_ready);
    end
  endtask

  task automatic test_single_write;
    int w0 = we_cnt;
    int d0 = done_cnt;
    send_hdr(12'h553, 12'h000, 1'b1, -1, 0);
    send_data(8'h09);
    checks++;
    if ({mem_we, slave_ready} !== 2'b00) begin
      failures++;
      $display("FAIL sw_cycle19: got we/ready=%b expected 00", {mem_we, slave_ready});
    end
    tick();
    checks++;
    if ({mem_we, mem_address, mem_wdata} !== {1'b1, 12'h553, 8'h09}) begin
      failures++;
      $display("FAIL sw_strobe: got we=%b addr=%h data=%h expected 1/553/09", mem_we, mem_address, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_we, rx_done, slave_ready} !== 3'b011) begin
      failures++;
      $display("FAIL sw_done: got we/done/ready=%b expected 011", {mem_we, rx_done, slave_ready});
    end
    tick();
    checks++;
    if (rx_done !== 1'b0 || (we_cnt - w0) != 1 || (done_cnt - d0) != 1) begin
      failures++;
      $display("FAIL sw_counts: got done=%b we=%0d dones=%0d expected 0/1/1", rx_done, we_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_read_burst;
    int w0 = we_cnt;
    int r0 = req_cnt;
    int d0 = done_cnt;
    logic [11:0] exp_addr;
    logic seen;
    send_hdr(12'h553, 12'h003, 1'b0, -1, 0);
    master_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      exp_addr = 12'h553 + 12'(b);
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        tick();
        if (read_req === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b1 || mem_address !== exp_addr) begin
        failures++;
        $display("FAIL rd_req_beat%0d: got seen=%b addr=%h expected 1/%h", b, seen, mem_address, exp_addr);
      end
      tick();
      read_ack = 1'b1;
      tick();
      read_ack = 1'b0;
    end
    tick();
    checks++;
    if (rx_done !== 1'b1) begin
      failures++;
      $display("FAIL rd_done: got %b expected 1", rx_done);
    end
    tick();
    checks++;
    if ((we_cnt - w0) != 0 || (req_cnt - r0) != 3 || (done_cnt - d0) != 1) begin
      failures++;
      $display("FAIL rd_counts: got we=%0d req=%0d done=%0d expected 0/3/1", we_cnt - w0, req_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_wrap_stall;
    int w0 = we_cnt;
    send_hdr(12'hFFF, 12'h002, 1'b1, -1, 0);
    send_data(8'hA5);
    slave_busy = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL stall_cycle%0d: got we=%b expected 0", s, mem_we);
      end
    end
    slave_busy = 1'b0;
    tick();
    checks++;
    if ({mem_we, mem_address, mem_wdata} !== {1'b1, 12'hFFF, 8'hA5}) begin
      failures++;
      $display("FAIL wrap_beat0: got we=%b addr=%h data=%h expected 1/fff/a5", mem_we, mem_address, mem_wdata);
    end
    send_data(8'h3C);
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL wrap_early: got we=%b expected 0", mem_we);
    end
    tick();
    checks++;
    if ({mem_we, mem_address, mem_wdata} !== {1'b1, 12'h000, 8'h3C}) begin
      failures++;
      $display("FAIL wrap_beat1: got we=%b addr=%h data=%h expected 1/000/3c", mem_we, mem_address, mem_wdata);
    end
    tick();
    checks++;
    if (rx_done !== 1'b1 || (we_cnt - w0) != 2) begin
      failures++;
      $display("FAIL wrap_done: got done=%b strobes=%0d expected 1/2", rx_done, we_cnt - w0);
    end
    tick();
  endtask

  task automatic test_illegal;
    logic [11:0] a0;
    logic [7:0]  d0;
    a0 = mem_address;
    d0 = mem_wdata;
    master_valid = 1'b1;
    write_en     = 1'b1;
    read_en      = 1'b1;
    rx_address   = 1'b1;
    rx_burst_num = 1'b1;
    tick();
    master_valid = 1'b0;
    write_en     = 1'b0;
    read_en      = 1'b0;
    checks++;
    if ({proto_err, slave_ready, mem_we, read_req, rx_done} !== 5'b11000 ||
        mem_address !== a0 || mem_wdata !== d0) begin
      failures++;
      $display("FAIL illegal_pulse: got err/rdy/we/req/done=%b addr=%h data=%h expected 11000/%h/%h",
               {proto_err, slave_ready, mem_we, read_req, rx_done}, mem_address, mem_wdata, a0, d0);
    end
    tick();
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL illegal_one_cycle: got %b expected 0", proto_err);
    end
    send_hdr(12'h0AA, 12'h000, 1'b1, -1, 0);
    send_data(8'h5A);
    tick();
    checks++;
    if ({mem_we, mem_address, mem_wdata} !== {1'b1, 12'h0AA, 8'h5A}) begin
      failures++;
      $display("FAIL illegal_then_write: got we=%b addr=%h data=%h expected 1/0aa/5a", mem_we, mem_address, mem_wdata);
    end
    tick();
  endtask

  task automatic test_gapped;
    send_hdr(12'h321, 12'h000, 1'b1, 5, 3);
    send_data(8'hC7);
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL gap_early: got we=%b expected 0", mem_we);
    end
    tick();
    checks++;
    if ({mem_we, mem_address, mem_wdata} !== {1'b1, 12'h321, 8'hC7}) begin
      failures++;
      $display("FAIL gap_strobe: got we=%b addr=%h data=%h expected 1/321/c7", mem_we, mem_address, mem_wdata);
    end
    tick();
    checks++;
    if (rx_done !== 1'b1) begin
      failures++;
      $display("FAIL gap_done: got %b expected 1", rx_done);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int w0;
    int d0;
    send_hdr(12'h7E1, 12'h000, 1'b1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      master_valid = 1'b1;
      rx_data      = 1'b1;
      tick();
    end
    master_valid = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if ({slave_ready, rx_done, mem_we, read_req, proto_err, mem_address, mem_wdata} !== 25'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h expected 0000000",
               {slave_ready, rx_done, mem_we, read_req, proto_err, mem_address, mem_wdata});
    end
    w0 = we_cnt;
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    checks++;
    if (slave_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready: got %b expected 1", slave_ready);
    end
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if ((we_cnt - w0) != 0 || (done_cnt - d0) != 0) begin
      failures++;
      $display("FAIL midreset_quiet: got we=%0d done=%0d expected 0/0", we_cnt - w0, done_cnt - d0);
    end
    send_hdr(12'h0F0, 12'h000, 1'b1, -1, 0);
    send_data(8'h96);
    tick();
    checks++;
    if ({mem_we, mem_address, mem_wdata} !== {1'b1, 12'h0F0, 8'h96}) begin
      failures++;
      $display("FAIL midreset_rewrite: got we=%b addr=%h data=%h expected 1/0f0/96", mem_we, mem_address, mem_wdata);
    end
    tick();
    checks++;
    if (rx_done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_done: got %b expected 1", rx_done);
    end
    tick();
  endtask

  initial begin
    reset        = 1'b0;
    master_valid = 1'b0;
    write_en     = 1'b0;
    read_en      = 1'b0;
    rx_address   = 1'b0;
    rx_burst_num = 1'b0;
    rx_data      = 1'b0;
    slave_busy   = 1'b0;
    read_ack     = 1'b0;
    #2;
    test_reset();
    test_single_write();
    test_read_burst();
    test_wrap_stall();
    test_illegal();
    test_gapped();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
